// File: rtl/riscv_commit_trace.sv
// Commit/trace buffer: captures per-cycle regfile writeback and data-memory accesses into a timestamped FIFO.
// Latency: an event captured at edge N is visible on the readout from cycle N+1. Readout is valid/ready; a full FIFO drops the newest or overwrites the oldest (WRAP).
module riscv_commit_trace #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 9,
    parameter int DEPTH          = 8,
    parameter int TS_W           = 16,
    parameter int MODE           = 0,
    parameter int WRAP           = 0,
    parameter int FREEZE_ON_HALT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       reg_write_sig,
    input  logic [4:0]                 reg_num,
    input  logic [DATA_W-1:0]          reg_data,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W-1:0]          rd_data,
    input  logic                       halt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TS_W-1:0]            out_ts,
    output logic                       out_reg_v,
    output logic [4:0]                 out_reg_num,
    output logic [DATA_W-1:0]          out_reg_data,
    output logic [1:0]                 out_mem_type,
    output logic [ADDR_W-1:0]          out_mem_addr,
    output logic [DATA_W-1:0]          out_mem_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic [15:0]                drop_cnt,
    output logic                       frozen
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic              reg_v;
        logic [4:0]        reg_num;
        logic [DATA_W-1:0] reg_data;
        logic [1:0]        mem_type;
        logic [ADDR_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [15:0]     drop_q, drop_d;
    logic            frozen_q, frozen_d;

    logic   reg_ev, mem_ev, push, pop, full_w, we;
    entry_t new_ent, head;

    // Build the entry; a half that is filtered out or absent stays zero.
    always_comb begin
        reg_ev  = reg_write_sig && (reg_num != 5'd0) && (MODE != 2);
        mem_ev  = (wr || rd) && (MODE != 1);
        new_ent = '0;
        new_ent.ts = ts_q;
        if (reg_ev) begin
            new_ent.reg_v    = 1'b1;
            new_ent.reg_num  = reg_num;
            new_ent.reg_data = reg_data;
        end
        if (mem_ev) begin
            new_ent.mem_type = wr ? 2'b10 : 2'b11;
            new_ent.mem_addr = addr;
            new_ent.mem_data = wr ? wr_data : rd_data;
        end
    end

    assign full_w = (count_q == CW'(DEPTH));
    assign push   = (reg_ev || mem_ev) && !frozen_q && !clear;
    assign pop    = (count_q != '0) && out_ready && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        frozen_d = frozen_q;
        ts_d     = ts_q + TS_W'(1);
        we       = 1'b0;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = '0;
            frozen_d = 1'b0;
        end else begin
            if (push && full_w && !pop) begin
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
                // Overwrite mode: slot at wr_ptr is the oldest entry, so both pointers step together.
                if (WRAP == 1) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
            end else begin
                if (push) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end
            if ((FREEZE_ON_HALT != 0) && halt) begin
                frozen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ts_q     <= '0;
            drop_q   <= '0;
            frozen_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ts_q     <= ts_d;
            drop_q   <= drop_d;
            frozen_q <= frozen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem_q[wr_ptr_q] <= new_ent;
        end
    end

    // Readout fields are forced to zero while empty so stale storage never leaks out.
    assign head         = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign out_valid    = (count_q != '0);
    assign out_ts       = head.ts;
    assign out_reg_v    = head.reg_v;
    assign out_reg_num  = head.reg_num;
    assign out_reg_data = head.reg_data;
    assign out_mem_type = head.mem_type;
    assign out_mem_addr = head.mem_addr;
    assign out_mem_data = head.mem_data;
    assign count        = count_q;
    assign full         = full_w;
    assign drop_cnt     = drop_q;
    assign frozen       = frozen_q;

endmodule

// File: tb/tb_riscv_commit_trace.sv
// Directed bench: three instances (default, reg-only filter, overwrite-on-full) share one stimulus stream.
module tb_riscv_commit_trace;

    logic        clk = 1'b0;
    logic        reset, clear, reg_write_sig, wr, rd, halt, out_ready;
    logic [4:0]  reg_num;
    logic [31:0] reg_data, wr_data, rd_data;
    logic [8:0]  addr;

    logic        ov    [3];
    logic [15:0] ots   [3];
    logic        orv   [3];
    logic [4:0]  orn   [3];
    logic [31:0] ord   [3];
    logic [1:0]  omt   [3];
    logic [8:0]  oma   [3];
    logic [31:0] omd   [3];
    logic [3:0]  cnt   [3];
    logic        fl    [3];
    logic [15:0] drp   [3];
    logic        frz   [3];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    riscv_commit_trace #(.MODE(0), .WRAP(0)) dut0 (
        .clk(clk), .reset(reset), .clear(clear), .reg_write_sig(reg_write_sig),
        .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .halt(halt), .out_valid(ov[0]),
        .out_ready(out_ready), .out_ts(ots[0]), .out_reg_v(orv[0]), .out_reg_num(orn[0]),
        .out_reg_data(ord[0]), .out_mem_type(omt[0]), .out_mem_addr(oma[0]),
        .out_mem_data(omd[0]), .count(cnt[0]), .full(fl[0]), .drop_cnt(drp[0]), .frozen(frz[0]));

    riscv_commit_trace #(.MODE(1), .WRAP(0)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .reg_write_sig(reg_write_sig),
        .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .halt(halt), .out_valid(ov[1]),
        .out_ready(out_ready), .out_ts(ots[1]), .out_reg_v(orv[1]), .out_reg_num(orn[1]),
        .out_reg_data(ord[1]), .out_mem_type(omt[1]), .out_mem_addr(oma[1]),
        .out_mem_data(omd[1]), .count(cnt[1]), .full(fl[1]), .drop_cnt(drp[1]), .frozen(frz[1]));

    riscv_commit_trace #(.MODE(0), .WRAP(1)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .reg_write_sig(reg_write_sig),
        .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .halt(halt), .out_valid(ov[2]),
        .out_ready(out_ready), .out_ts(ots[2]), .out_reg_v(orv[2]), .out_reg_num(orn[2]),
        .out_reg_data(ord[2]), .out_mem_type(omt[2]), .out_mem_addr(oma[2]),
        .out_mem_data(omd[2]), .count(cnt[2]), .full(fl[2]), .drop_cnt(drp[2]), .frozen(frz[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write_sig = 0; reg_num = 0; reg_data = 0;
        wr = 0; rd = 0; addr = 0; wr_data = 0; rd_data = 0; halt = 0; clear = 0;
    endtask

    task automatic reg_ev(input logic [4:0] n, input logic [31:0] d);
        idle();
        reg_write_sig = 1; reg_num = n; reg_data = d;
    endtask

    task automatic do_clear();
        idle();
        clear = 1; step(); clear = 0;
    endtask

    initial begin
        idle();
        out_ready = 0;
        reset = 1;
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", 64'(ov[k]), 0);
            chk("rst_count", 64'(cnt[k]), 0);
            chk("rst_drop",  64'(drp[k]), 0);
            chk("rst_frozen", 64'(frz[k]), 0);
            chk("rst_data",  64'(ord[k]), 0);
        end
        reset = 0;
        repeat (3) step();

        // Register write captured with ts=3.
        reg_ev(5'd5, 32'hDEADBEEF);
        step(); idle();
        chk("t1_valid", 64'(ov[0]), 1);
        chk("t1_ts",    64'(ots[0]), 3);
        chk("t1_regv",  64'(orv[0]), 1);
        chk("t1_regn",  64'(orn[0]), 5);
        chk("t1_regd",  64'(ord[0]), 64'hDEADBEEF);
        chk("t1_mtype", 64'(omt[0]), 0);
        chk("t1_count", 64'(cnt[0]), 1);
        step();
        chk("t1_hold",  64'(ord[0]), 64'hDEADBEEF);
        out_ready = 1; step(); out_ready = 0;
        chk("t1_drained", 64'(cnt[0]), 0);
        chk("t1_novalid", 64'(ov[0]), 0);

        // x0 write plus store: only the store half survives; reg-only filter sees nothing.
        idle();
        reg_write_sig = 1; reg_num = 0; reg_data = 32'h99;
        wr = 1; addr = 9'h10; wr_data = 32'h55;
        step(); idle();
        chk("t2_count",  64'(cnt[0]), 1);
        chk("t2_regv",   64'(orv[0]), 0);
        chk("t2_regd",   64'(ord[0]), 0);
        chk("t2_mtype",  64'(omt[0]), 2);
        chk("t2_addr",   64'(oma[0]), 64'h10);
        chk("t2_mdata",  64'(omd[0]), 64'h55);
        chk("t2_m1_cnt", 64'(cnt[1]), 0);
        chk("t2_w1_cnt", 64'(cnt[2]), 1);
        out_ready = 1; step(); out_ready = 0;

        // Ten events into an 8-deep FIFO with no readout.
        for (int i = 1; i <= 10; i++) begin
            reg_ev(5'd1, 32'(i));
            step();
        end
        idle();
        chk("t3_full",   64'(fl[0]), 1);
        chk("t3_count",  64'(cnt[0]), 8);
        chk("t3_drop",   64'(drp[0]), 2);
        chk("t3_wfull",  64'(fl[2]), 1);
        chk("t3_wcount", 64'(cnt[2]), 8);
        chk("t3_wdrop",  64'(drp[2]), 2);
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            chk("t3_order",  64'(ord[0]), 64'(i));
            chk("t3_worder", 64'(ord[2]), 64'(i + 2));
            step();
        end
        out_ready = 0;
        chk("t3_empty", 64'(cnt[0]), 0);

        // Full with simultaneous pop: push accepted, no drop.
        do_clear();
        chk("t4_clr_drop", 64'(drp[0]), 0);
        for (int i = 1; i <= 8; i++) begin
            reg_ev(5'd2, 32'(i));
            step();
        end
        chk("t4_full", 64'(fl[0]), 1);
        reg_ev(5'd2, 32'd99);
        out_ready = 1;
        step(); idle(); out_ready = 0;
        chk("t4_count", 64'(cnt[0]), 8);
        chk("t4_drop",  64'(drp[0]), 0);
        chk("t4_head",  64'(ord[0]), 2);
        chk("t4_wdrop", 64'(drp[2]), 0);

        // Halt with a load in the same cycle; later events are blocked.
        do_clear();
        reg_ev(5'd7, 32'h1234);
        rd = 1; addr = 9'h40; rd_data = 32'h1234; halt = 1;
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            reg_ev(5'd3, 32'(i + 100));
            step();
        end
        idle();
        chk("t5_count",  64'(cnt[0]), 1);
        chk("t5_frozen", 64'(frz[0]), 1);
        chk("t5_regn",   64'(orn[0]), 7);
        chk("t5_mtype",  64'(omt[0]), 3);
        chk("t5_mdata",  64'(omd[0]), 64'h1234);
        do_clear();
        chk("t5_clr_cnt", 64'(cnt[0]), 0);
        chk("t5_clr_frz", 64'(frz[0]), 0);
        chk("t5_clr_vld", 64'(ov[0]), 0);
        reg_ev(5'd9, 32'hABCD);
        step(); idle();
        chk("t5_resume", 64'(cnt[0]), 1);
        chk("t5_resd",   64'(ord[0]), 64'hABCD);

        // Reset with contents discards everything.
        reg_ev(5'd4, 32'h1);
        step(); idle();
        reset = 1; step(); reset = 0;
        chk("t6_rst_cnt", 64'(cnt[0]), 0);
        chk("t6_rst_vld", 64'(ov[0]), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
